// File: rtl/decode_exec_stage_pkg.sv
// Shared types and default widths for the decode/execute boundary.
// The default widths are also used by the hazard controller.
package decode_exec_stage_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic alu;
    logic imm;
    logic mem;
    logic write;
  } op_flags_t;

  localparam op_flags_t OP_NONE = '{alu: 1'b0, imm: 1'b0, mem: 1'b0, write: 1'b0};

endpackage

// File: rtl/decode_exec_stage_operand_fwd_mux.sv
// Execute-stage operand select: mem result over writeback data over the
// registered value. Register 0 is never forwarded and always reads as zero.
module operand_fwd_mux
  import decode_exec_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              me_sel,
  input  logic              we_sel,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] val
);

  always_comb begin
    val = reg_data;
    if (addr == REG_AW'(REG_ZERO)) begin
      val = '0;
    end else if (me_sel) begin
      val = mem_data;
    end else if (we_sel) begin
      val = wb_data;
    end
  end

endmodule

// File: rtl/decode_exec_stage.sv
// Decode->execute pipeline register with bubble insertion, operand forwarding
// and saturating stall/bubble performance counters.
module decode_exec_stage
  import decode_exec_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_dec_valid,
  input  logic              w_dec_alu_op,
  input  logic              w_dec_imm_op,
  input  logic              w_dec_mem_op,
  input  logic              w_dec_write_op,
  input  logic [REG_AW-1:0] w_dec_rs_addr,
  input  logic [REG_AW-1:0] w_dec_rt_addr,
  input  logic [REG_AW-1:0] w_dec_rd_addr,
  input  logic [DATA_W-1:0] w_dec_rs_data,
  input  logic [DATA_W-1:0] w_dec_rt_data,
  input  logic [DATA_W-1:0] w_dec_imm,
  input  logic [DATA_W-1:0] w_dec_pc,
  input  logic              w_stall,
  input  logic              w_flush,
  input  logic              w_me_rs_bypass,
  input  logic              w_me_rt_bypass,
  input  logic              w_we_rs_bypass,
  input  logic              w_we_rt_bypass,
  input  logic [DATA_W-1:0] w_mem_alu_result,
  input  logic [DATA_W-1:0] w_wb_data,
  output logic              w_ex_valid,
  output logic              w_ex_alu_op,
  output logic              w_ex_imm_op,
  output logic              w_ex_mem_op,
  output logic              w_ex_write_op,
  output logic [REG_AW-1:0] w_ex_rs_addr,
  output logic [REG_AW-1:0] w_ex_rt_addr,
  output logic [REG_AW-1:0] w_ex_rd_addr,
  output logic [DATA_W-1:0] w_ex_rs_val,
  output logic [DATA_W-1:0] w_ex_rt_val,
  output logic [DATA_W-1:0] w_ex_imm,
  output logic [DATA_W-1:0] w_ex_pc,
  output logic              w_dec_hold,
  output logic [CNT_W-1:0]  w_stall_cnt,
  output logic [CNT_W-1:0]  w_bubble_cnt
);

  logic              valid_q,   valid_d;
  op_flags_t         ops_q,     ops_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [DATA_W-1:0] pc_q,      pc_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic hold_c;
  logic bubble_c;

  // Hold is forced low while reset is asserted so upstream never freezes in reset.
  assign hold_c   = reset_n & w_stall & ~w_flush;
  assign bubble_c = w_stall | w_flush;

  always_comb begin
    valid_d      = 1'b0;
    ops_d        = OP_NONE;
    rs_addr_d    = '0;
    rt_addr_d    = '0;
    rd_addr_d    = '0;
    rs_data_d    = '0;
    rt_data_d    = '0;
    imm_d        = '0;
    pc_d         = '0;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (!bubble_c) begin
      valid_d   = w_dec_valid;
      rs_addr_d = w_dec_rs_addr;
      rt_addr_d = w_dec_rt_addr;
      rd_addr_d = w_dec_rd_addr;
      rs_data_d = w_dec_rs_data;
      rt_data_d = w_dec_rt_data;
      imm_d     = w_dec_imm;
      pc_d      = w_dec_pc;
      if (w_dec_valid) begin
        ops_d = '{alu: w_dec_alu_op, imm: w_dec_imm_op,
                  mem: w_dec_mem_op, write: w_dec_write_op};
      end
    end

    if (hold_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bubble_c && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      ops_q        <= OP_NONE;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ops_q        <= ops_d;
      rs_addr_q    <= rs_addr_d;
      rt_addr_q    <= rt_addr_d;
      rd_addr_q    <= rd_addr_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_fwd (
    .addr     (rs_addr_q),
    .reg_data (rs_data_q),
    .me_sel   (w_me_rs_bypass),
    .we_sel   (w_we_rs_bypass),
    .mem_data (w_mem_alu_result),
    .wb_data  (w_wb_data),
    .val      (w_ex_rs_val)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_fwd (
    .addr     (rt_addr_q),
    .reg_data (rt_data_q),
    .me_sel   (w_me_rt_bypass),
    .we_sel   (w_we_rt_bypass),
    .mem_data (w_mem_alu_result),
    .wb_data  (w_wb_data),
    .val      (w_ex_rt_val)
  );

  assign w_ex_valid    = valid_q;
  assign w_ex_alu_op   = ops_q.alu;
  assign w_ex_imm_op   = ops_q.imm;
  assign w_ex_mem_op   = ops_q.mem;
  assign w_ex_write_op = ops_q.write;
  assign w_ex_rs_addr  = rs_addr_q;
  assign w_ex_rt_addr  = rt_addr_q;
  assign w_ex_rd_addr  = rd_addr_q;
  assign w_ex_imm      = imm_q;
  assign w_ex_pc       = pc_q;
  assign w_dec_hold    = hold_c;
  assign w_stall_cnt   = stall_cnt_q;
  assign w_bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_decode_exec_stage.sv
// Directed bench for decode_exec_stage: default-width instance plus a
// 4-bit-counter instance for saturation.
module tb_decode_exec_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        dec_valid, dec_alu, dec_imm_op, dec_mem, dec_write;
  logic [4:0]  dec_rs_addr, dec_rt_addr, dec_rd_addr;
  logic [31:0] dec_rs_data, dec_rt_data, dec_imm, dec_pc;
  logic        stall, flush, me_rs, me_rt, we_rs, we_rt;
  logic [31:0] mem_res, wb_data;

  logic        ex_valid, ex_alu, ex_imm_op, ex_mem, ex_write, hold;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        ex_valid4, ex_alu4, ex_imm_op4, ex_mem4, ex_write4, hold4;
  logic [4:0]  ex_rs_addr4, ex_rt_addr4, ex_rd_addr4;
  logic [31:0] ex_rs_val4, ex_rt_val4, ex_imm4, ex_pc4;
  logic [3:0]  stall_cnt4, bubble_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  decode_exec_stage dut (
    .clock(clock), .reset_n(reset_n),
    .w_dec_valid(dec_valid), .w_dec_alu_op(dec_alu), .w_dec_imm_op(dec_imm_op),
    .w_dec_mem_op(dec_mem), .w_dec_write_op(dec_write),
    .w_dec_rs_addr(dec_rs_addr), .w_dec_rt_addr(dec_rt_addr), .w_dec_rd_addr(dec_rd_addr),
    .w_dec_rs_data(dec_rs_data), .w_dec_rt_data(dec_rt_data),
    .w_dec_imm(dec_imm), .w_dec_pc(dec_pc),
    .w_stall(stall), .w_flush(flush),
    .w_me_rs_bypass(me_rs), .w_me_rt_bypass(me_rt),
    .w_we_rs_bypass(we_rs), .w_we_rt_bypass(we_rt),
    .w_mem_alu_result(mem_res), .w_wb_data(wb_data),
    .w_ex_valid(ex_valid), .w_ex_alu_op(ex_alu), .w_ex_imm_op(ex_imm_op),
    .w_ex_mem_op(ex_mem), .w_ex_write_op(ex_write),
    .w_ex_rs_addr(ex_rs_addr), .w_ex_rt_addr(ex_rt_addr), .w_ex_rd_addr(ex_rd_addr),
    .w_ex_rs_val(ex_rs_val), .w_ex_rt_val(ex_rt_val),
    .w_ex_imm(ex_imm), .w_ex_pc(ex_pc),
    .w_dec_hold(hold), .w_stall_cnt(stall_cnt), .w_bubble_cnt(bubble_cnt)
  );

  decode_exec_stage #(.CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .w_dec_valid(dec_valid), .w_dec_alu_op(dec_alu), .w_dec_imm_op(dec_imm_op),
    .w_dec_mem_op(dec_mem), .w_dec_write_op(dec_write),
    .w_dec_rs_addr(dec_rs_addr), .w_dec_rt_addr(dec_rt_addr), .w_dec_rd_addr(dec_rd_addr),
    .w_dec_rs_data(dec_rs_data), .w_dec_rt_data(dec_rt_data),
    .w_dec_imm(dec_imm), .w_dec_pc(dec_pc),
    .w_stall(stall), .w_flush(flush),
    .w_me_rs_bypass(me_rs), .w_me_rt_bypass(me_rt),
    .w_we_rs_bypass(we_rs), .w_we_rt_bypass(we_rt),
    .w_mem_alu_result(mem_res), .w_wb_data(wb_data),
    .w_ex_valid(ex_valid4), .w_ex_alu_op(ex_alu4), .w_ex_imm_op(ex_imm_op4),
    .w_ex_mem_op(ex_mem4), .w_ex_write_op(ex_write4),
    .w_ex_rs_addr(ex_rs_addr4), .w_ex_rt_addr(ex_rt_addr4), .w_ex_rd_addr(ex_rd_addr4),
    .w_ex_rs_val(ex_rs_val4), .w_ex_rt_val(ex_rt_val4),
    .w_ex_imm(ex_imm4), .w_ex_pc(ex_pc4),
    .w_dec_hold(hold4), .w_stall_cnt(stall_cnt4), .w_bubble_cnt(bubble_cnt4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [3:0] ops, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic [31:0] imm, input logic [31:0] pc);
    dec_valid = v;
    {dec_alu, dec_imm_op, dec_mem, dec_write} = ops;
    dec_rs_addr = rs; dec_rt_addr = rt; dec_rd_addr = rd;
    dec_rs_data = rsd; dec_rt_data = rtd; dec_imm = imm; dec_pc = pc;
  endtask

  function automatic logic [3:0] flags();
    return {ex_alu, ex_imm_op, ex_mem, ex_write};
  endfunction

  initial begin
    // reset with random inputs
    reset_n = 1'b0;
    set_instr(1'($urandom), 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom, $urandom, $urandom, $urandom);
    stall = 1'b1; flush = 1'b0;
    me_rs = 1'($urandom); me_rt = 1'($urandom); we_rs = 1'b1; we_rt = 1'b1;
    mem_res = $urandom; wb_data = $urandom;
    step(); step();
    check("rst_valid", 64'(ex_valid), 64'h0);
    check("rst_flags", 64'(flags()), 64'h0);
    check("rst_addrs", 64'({ex_rs_addr, ex_rt_addr, ex_rd_addr}), 64'h0);
    check("rst_vals", {ex_rs_val, ex_rt_val}, 64'h0);
    check("rst_imm_pc", {ex_imm, ex_pc}, 64'h0);
    check("rst_hold", 64'(hold), 64'h0);
    check("rst_cnts", 64'({stall_cnt, bubble_cnt}), 64'h0);
    check("rst_dut4_all", 64'(|{ex_valid4, ex_alu4, ex_imm_op4, ex_mem4, ex_write4, hold4,
                                 ex_rs_addr4, ex_rt_addr4, ex_rd_addr4, ex_rs_val4,
                                 ex_rt_val4, ex_imm4, ex_pc4, stall_cnt4, bubble_cnt4}), 64'h0);

    // add r3,r1,r2
    stall = 1'b0; flush = 1'b0;
    me_rs = 1'b0; me_rt = 1'b0; we_rs = 1'b0; we_rt = 1'b0;
    mem_res = 32'h0; wb_data = 32'h0;
    set_instr(1'b1, 4'b1001, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 32'h100);
    reset_n = 1'b1;
    step();
    check("add_valid", 64'(ex_valid), 64'h1);
    check("add_flags", 64'(flags()), 64'h9);
    check("add_rd", 64'(ex_rd_addr), 64'h3);
    check("add_vals", {ex_rs_val, ex_rt_val}, 64'h00000011_00000022);
    check("add_pc", 64'(ex_pc), 64'h100);

    // load-use stall on add r5,r4,r3
    set_instr(1'b1, 4'b1001, 5'd4, 5'd3, 5'd5, 32'h44, 32'h33, 32'h0, 32'h104);
    stall = 1'b1;
    #1;
    check("lu_hold", 64'(hold), 64'h1);
    step();
    check("lu_bubble", 64'({ex_valid, flags()}), 64'h0);
    check("lu_cnts", 64'({stall_cnt, bubble_cnt}), 64'h0001_0001);
    stall = 1'b0;
    #1;
    check("lu_hold_off", 64'(hold), 64'h0);
    step();
    check("lu_recapture", 64'({ex_valid, flags(), ex_rs_addr, ex_rd_addr}),
          64'({1'b1, 4'b1001, 5'd4, 5'd5}));
    check("lu_cnts_hold", 64'({stall_cnt, bubble_cnt}), 64'h0001_0001);

    // forwarding priority on rs (r4)
    me_rs = 1'b1; we_rs = 1'b1; mem_res = 32'hAAAA0000; wb_data = 32'h5555;
    #1;
    check("fwd_me_wins", 64'(ex_rs_val), 64'hAAAA0000);
    me_rs = 1'b0;
    #1;
    check("fwd_we", 64'(ex_rs_val), 64'h5555);
    we_rs = 1'b0;
    #1;
    check("fwd_none", 64'(ex_rs_val), 64'h44);
    me_rt = 1'b1;
    #1;
    check("fwd_rt_me", 64'(ex_rt_val), 64'hAAAA0000);
    me_rt = 1'b0;

    // rt = r0 never forwarded
    set_instr(1'b1, 4'b1100, 5'd6, 5'd0, 5'd7, 32'h66, 32'h77, 32'hFFFFFFF0, 32'h108);
    step();
    we_rt = 1'b1; wb_data = 32'hDEAD;
    #1;
    check("r0_we", 64'(ex_rt_val), 64'h0);
    me_rt = 1'b1;
    #1;
    check("r0_me", 64'(ex_rt_val), 64'h0);
    check("imm_cap", 64'(ex_imm), 64'hFFFFFFF0);
    me_rt = 1'b0; we_rt = 1'b0;

    // invalid decode: flags forced low, not a bubble
    set_instr(1'b0, 4'b1111, 5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 32'h3, 32'h10C);
    step();
    check("inv_flags", 64'({ex_valid, flags()}), 64'h0);
    check("inv_rd", 64'(ex_rd_addr), 64'hA);
    check("inv_cnts", 64'({stall_cnt, bubble_cnt}), 64'h0001_0001);

    // stall + flush together
    set_instr(1'b1, 4'b0011, 5'd1, 5'd2, 5'd11, 32'h5, 32'h6, 32'h7, 32'h110);
    stall = 1'b1; flush = 1'b1;
    #1;
    check("sf_hold", 64'(hold), 64'h0);
    step();
    check("sf_bubble", 64'({ex_valid, flags()}), 64'h0);
    check("sf_cnts", 64'({stall_cnt, bubble_cnt}), 64'h0001_0002);

    // flush alone zeroes all fields
    stall = 1'b0;
    step();
    check("fl_fields", 64'({ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_pc}), 64'h0);
    check("fl_cnts", 64'({stall_cnt, bubble_cnt}), 64'h0001_0003);
    flush = 1'b0;

    // saturation on 4-bit counters
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("sat4_stall", 64'(stall_cnt4), 64'hF);
    check("sat4_bubble", 64'(bubble_cnt4), 64'hF);
    check("cnt16_stall", 64'(stall_cnt), 64'd21);
    for (int i = 0; i < 3; i++) step();
    check("sat4_stays", 64'({stall_cnt4, bubble_cnt4}), 64'hFF);
    check("cnt16_bubble", 64'(bubble_cnt), 64'd26);

    // reset mid-stall clears immediately, then normal capture
    reset_n = 1'b0;
    #1;
    check("mid_rst_cnts", 64'({stall_cnt, bubble_cnt}), 64'h0);
    check("mid_rst_hold", 64'(hold), 64'h0);
    stall = 1'b0;
    set_instr(1'b1, 4'b0101, 5'd2, 5'd3, 5'd12, 32'h9, 32'hA, 32'h4, 32'h200);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_cap", 64'({ex_valid, flags(), ex_rd_addr}), 64'({1'b1, 4'b0101, 5'd12}));
    check("post_rst_pc", 64'(ex_pc), 64'h200);
    check("post_rst_cnts", 64'({stall_cnt, bubble_cnt}), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
